biquad_stage_sequencer: RTL
===========================

Name: biquad_stage_sequencer

Overview:
- Sequences one shared combinational first-order difference-equation datapath (diffEq) across two cascaded filter stages per audio sample: an HPF stage, then an LPF stage, forming the guitar band-pass.
- Owns all x[n-1]/y[n-1] history registers and latches pot frequencies per sample.
- Drives diffEq operands, waits a settle interval, and captures its output.
- Sits between the ADC sample strobe and the DAC/output register.

Parameters:
- N, 10, sample/datapath width in bits
- FS, 88200, sample rate driven on de_fs
- SETTLE, 4, clock cycles each stage holds operands before capture (≥1); covers diffEq combinational depth
- RESET_LEVEL, 512, reset/clear value of every history register (mid-scale of unsigned samples)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sample_valid  in  1  one-cycle strobe, new sample on sample_in
- sample_in  in  N  x[n], unsigned
- f_hpf  in  16  HPF corner (Hz)
- f_lpf  in  16  LPF corner (Hz)
- hpf_en  in  1  enable HPF stage
- lpf_en  in  1  enable LPF stage
- clear_hist  in  1  synchronous history clear/abort
- de_x  out  2×N  packed [0:1][N-1:0]; [0]=x[n], [1]=x[n-1] to diffEq
- de_y  out  N  y[n-1] to diffEq
- de_f  out  16  corner frequency to diffEq
- de_fs  out  17  constant FS
- de_filt_type  out  1  0=LPF, 1=HPF
- de_out  in  N  diffEq result
- sample_out  out  N  band-passed sample
- out_valid  out  1  one-cycle strobe, sample_out updated
- busy  out  1  high while not IDLE
- overrun  out  1  one-cycle pulse, sample dropped

Behaviour:
- Reset: state IDLE; all history registers, sample_out, and latched sample = RESET_LEVEL; out_valid=0, overrun=0, cnt=0; latched f_hpf/f_lpf=0.
- FSM states: IDLE, HPF, LPF.
- IDLE: on a clock edge with sample_valid=1, latch sample_in, f_hpf, f_lpf, hpf_en, lpf_en; cnt←0; go to HPF.
- HPF: de_x={sample, hpf_x_prev}, de_y=hpf_y_prev, de_f=latched f_hpf, de_filt_type=1. cnt increments each edge. At the edge where cnt==SETTLE-1: hpf_res←(hpf_en ? de_out : sample); hpf_x_prev←sample; hpf_y_prev←hpf_res value; cnt←0; go to LPF.
- LPF: de_x={hpf_res, lpf_x_prev}, de_y=lpf_y_prev, de_f=latched f_lpf, de_filt_type=0. At cnt==SETTLE-1: r=(lpf_en ? de_out : hpf_res); sample_out←r; lpf_x_prev←hpf_res; lpf_y_prev←r; out_valid←1 for one cycle; go to IDLE.
- IDLE operands: hold last LPF values.
- Latency: accept edge k → out_valid high in the cycle after edge k+2·SETTLE. Latency is constant regardless of stage enables; a disabled stage still occupies SETTLE cycles.
- busy = (state != IDLE).
- A sample_valid in the out_valid cycle is accepted (state is IDLE). Maximum throughput is one sample per 2·SETTLE+1 cycles.
- sample_valid while busy: sample ignored; overrun pulses 1 cycle; the in-flight computation is unaffected.
- clear_hist (synchronous, highest priority after reset): all histories ←RESET_LEVEL; any in-flight computation aborted to IDLE with no out_valid; sample_out unchanged. A sample_valid coincident with clear_hist is dropped without an overrun pulse.
- Pot inputs changing mid-computation have no effect until the next accept.
- No arithmetic in this block; widths pass through unchanged. de_fs is a constant.
- Asynchronous reset mid-operation: immediate return to reset values.

Decomposition:
- Package filt_pkg: typedef enum {IDLE, HPF, LPF} seq_state_t; constants FILT_LPF=0, FILT_HPF=1; FS_DEFAULT=88200.
- Sub-module filt_hist_reg: one stage's x_prev/y_prev pair with update and clear. Instantiated twice.
- The diffEq instance lives in the parent, not inside the sequencer.

Test Plan:
- Reset, SETTLE=4, stub diffEq returning de_x[0]+1; sample_valid with 700 → HPF cycles show de_x={700,512}, de_y=512, de_filt_type=1, de_f=f_hpf=2000; LPF cycles show de_x={701,512}, de_f=15000, de_filt_type=0; out_valid exactly 8 cycles after accept; sample_out=702.
- Second sample 300 after the first → HPF de_x={300,700}, de_y=701; LPF de_x={301,701}, de_y=702.
- hpf_en=0, lpf_en=1, sample 400 → LPF de_x[0]=400; sample_out=401; latency still 8 cycles.
- sample_valid 3 cycles after accept → overrun 1-cycle pulse; single out_valid; result from the first sample only.
- clear_hist during LPF → no out_valid; busy drops the next cycle; the next sample sees de_x[1]=512, de_y=512.
- Real diffEq instance with f_hpf=120, lpf_en=0; history primed to 523/523 (two samples at 523 with RESET_LEVEL=523); sample 525 → sample_out within 525±5.

Source files
------------

// File: rtl/filt_pkg.sv
// Shared types and constants for the two-stage HPF/LPF sequencer.
package filt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HPF  = 2'd1,
        LPF  = 2'd2
    } seq_state_t;

    localparam logic FILT_LPF = 1'b0;
    localparam logic FILT_HPF = 1'b1;

    localparam int unsigned FS_DEFAULT = 88200;
    localparam int unsigned F_W        = 16;
    localparam int unsigned FS_W       = 17;

endpackage

// File: rtl/filt_hist_reg.sv
// One filter stage's x[n-1]/y[n-1] history pair with update and synchronous clear.
module filt_hist_reg #(
    parameter int unsigned N           = 10,
    parameter int unsigned RESET_LEVEL = 512
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         update,
    input  logic [N-1:0] x_in,
    input  logic [N-1:0] y_in,
    output logic [N-1:0] x_prev,
    output logic [N-1:0] y_prev
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_prev <= N'(RESET_LEVEL);
            y_prev <= N'(RESET_LEVEL);
        end else if (clear) begin
            x_prev <= N'(RESET_LEVEL);
            y_prev <= N'(RESET_LEVEL);
        end else if (update) begin
            x_prev <= x_in;
            y_prev <= y_in;
        end
    end

endmodule

// File: rtl/biquad_stage_sequencer.sv
// Time-shares one external first-order diffEq datapath across an HPF then an LPF
// stage per sample; owns stage histories and registers all operands to the datapath.
module biquad_stage_sequencer
    import filt_pkg::*;
#(
    parameter int unsigned N           = 10,
    parameter int unsigned FS          = FS_DEFAULT,
    parameter int unsigned SETTLE      = 4,
    parameter int unsigned RESET_LEVEL = 512
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_valid,
    input  logic [N-1:0]         sample_in,
    input  logic [F_W-1:0]       f_hpf,
    input  logic [F_W-1:0]       f_lpf,
    input  logic                 hpf_en,
    input  logic                 lpf_en,
    input  logic                 clear_hist,
    output logic [0:1][N-1:0]    de_x,
    output logic [N-1:0]         de_y,
    output logic [F_W-1:0]       de_f,
    output logic [FS_W-1:0]      de_fs,
    output logic                 de_filt_type,
    input  logic [N-1:0]         de_out,
    output logic [N-1:0]         sample_out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    seq_state_t         state;
    seq_state_t         next_state;
    logic [CNT_W-1:0]   cnt;
    logic               settled;
    logic               accept;
    logic               hpf_done;
    logic               lpf_done;
    logic               drop;

    logic [N-1:0]       sample_q;
    logic [F_W-1:0]     f_lpf_q;
    logic               hpf_en_q;
    logic               lpf_en_q;
    logic [N-1:0]       hpf_res;
    logic [N-1:0]       hpf_res_next;
    logic [N-1:0]       lpf_res_next;

    logic [N-1:0]       hpf_x_prev;
    logic [N-1:0]       hpf_y_prev;
    logic [N-1:0]       lpf_x_prev;
    logic [N-1:0]       lpf_y_prev;

    assign de_fs = FS_W'(FS);

    // A disabled stage still spends its settle window, passing its input through.
    assign hpf_res_next = hpf_en_q ? de_out : sample_q;
    assign lpf_res_next = lpf_en_q ? de_out : hpf_res;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        hpf_done   = 1'b0;
        lpf_done   = 1'b0;
        drop       = 1'b0;
        settled    = (cnt == CNT_W'(SETTLE - 1));
        if (clear_hist) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        accept     = 1'b1;
                        next_state = HPF;
                    end
                end
                HPF: begin
                    drop = sample_valid;
                    if (settled) begin
                        hpf_done   = 1'b1;
                        next_state = LPF;
                    end
                end
                LPF: begin
                    drop = sample_valid;
                    if (settled) begin
                        lpf_done   = 1'b1;
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Settle counter, per-sample latches, stage results and status strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            sample_q   <= N'(RESET_LEVEL);
            f_lpf_q    <= '0;
            hpf_en_q   <= 1'b0;
            lpf_en_q   <= 1'b0;
            hpf_res    <= N'(RESET_LEVEL);
            sample_out <= N'(RESET_LEVEL);
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            out_valid <= lpf_done;
            overrun   <= drop;
            busy      <= (next_state != IDLE);
            if (clear_hist || accept || hpf_done || lpf_done) begin
                cnt <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (accept) begin
                sample_q <= sample_in;
                f_lpf_q  <= f_lpf;
                hpf_en_q <= hpf_en;
                lpf_en_q <= lpf_en;
            end
            if (hpf_done) hpf_res    <= hpf_res_next;
            if (lpf_done) sample_out <= lpf_res_next;
        end
    end

    // Operand registers: loaded at stage entry, held through settle and while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de_x         <= {N'(RESET_LEVEL), N'(RESET_LEVEL)};
            de_y         <= N'(RESET_LEVEL);
            de_f         <= '0;
            de_filt_type <= FILT_LPF;
        end else if (accept) begin
            de_x         <= {sample_in, hpf_x_prev};
            de_y         <= hpf_y_prev;
            de_f         <= f_hpf;
            de_filt_type <= FILT_HPF;
        end else if (hpf_done) begin
            de_x         <= {hpf_res_next, lpf_x_prev};
            de_y         <= lpf_y_prev;
            de_f         <= f_lpf_q;
            de_filt_type <= FILT_LPF;
        end
    end

    filt_hist_reg #(.N(N), .RESET_LEVEL(RESET_LEVEL)) u_hpf_hist (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear_hist),
        .update  (hpf_done),
        .x_in    (sample_q),
        .y_in    (hpf_res_next),
        .x_prev  (hpf_x_prev),
        .y_prev  (hpf_y_prev)
    );

    filt_hist_reg #(.N(N), .RESET_LEVEL(RESET_LEVEL)) u_lpf_hist (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear_hist),
        .update  (lpf_done),
        .x_in    (hpf_res),
        .y_in    (lpf_res_next),
        .x_prev  (lpf_x_prev),
        .y_prev  (lpf_y_prev)
    );

endmodule
